// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 8:1 selector scan sequencer.
// Holds the FSM state encoding, channel geometry and the y/w integrity helper.
package mux_scan_pkg;

  localparam int CH_COUNT = 8;
  localparam int CH_IDX_W = 3;
  localparam int SETTLE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } scan_state_e;

  // A healthy selector always drives w as the complement of y.
  function automatic logic yw_fault(input logic y, input logic w);
    return (y == w);
  endfunction

endpackage

// File: rtl/mux_scan_next_ch.sv
// Finds the lowest enabled channel strictly above cur_idx.
// When first is set, the search starts from channel 0 inclusive.
module mux_scan_next_ch
  import mux_scan_pkg::*;
(
  input  logic [CH_COUNT-1:0] mask,
  input  logic [CH_IDX_W-1:0] cur_idx,
  input  logic                first,
  output logic [CH_IDX_W-1:0] next_idx,
  output logic                found
);

  logic [CH_COUNT-1:0] elig_s;

  // Walk from the top down so the lowest eligible channel is the last one written.
  always_comb begin
    elig_s   = '0;
    next_idx = '0;
    for (int i = CH_COUNT - 1; i >= 0; i--) begin
      elig_s[i] = mask[i] & (first | (CH_IDX_W'(i) > cur_idx));
      next_idx  = elig_s[i] ? CH_IDX_W'(i) : next_idx;
    end
    found = |elig_s;
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Steps an 8:1 data selector through its enabled channels and assembles an
// 8-bit snapshot delivered over valid/ready, with change flags and y/w checking.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                cont,
  input  logic [CH_COUNT-1:0] ch_mask,
  output logic                mux_g,
  output logic                mux_a,
  output logic                mux_b,
  output logic                mux_c,
  input  logic                mux_y,
  input  logic                mux_w,
  output logic [CH_COUNT-1:0] scan_data,
  output logic                scan_valid,
  input  logic                scan_ready,
  output logic [CH_COUNT-1:0] chg,
  output logic                busy,
  output logic                err
);

  localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES - 1);

  scan_state_e         state_r, state_nxt_s;
  logic [CH_IDX_W-1:0] ch_r, ch_nxt_s;
  logic [CH_COUNT-1:0] mask_r, mask_nxt_s;
  logic [SETTLE_W-1:0] settle_r, settle_nxt_s;
  logic [CH_COUNT-1:0] snap_r, snap_nxt_s;
  logic [CH_COUNT-1:0] data_r, data_nxt_s;
  logic [CH_COUNT-1:0] chg_r, chg_nxt_s;
  logic [CH_COUNT-1:0] prev_r, prev_nxt_s;
  logic                valid_r, valid_nxt_s;
  logic                err_r, err_nxt_s;
  logic                busy_r, busy_nxt_s;
  logic                mux_g_r;

  logic                nc_first_s;
  logic [CH_COUNT-1:0] nc_mask_s;
  logic [CH_IDX_W-1:0] nc_idx_s;
  logic                nc_found_s;

  // Outside SAMPLE the search is for the first channel of a new scan over the live mask.
  assign nc_first_s = (state_r != SAMPLE);
  assign nc_mask_s  = nc_first_s ? ch_mask : mask_r;

  mux_scan_next_ch u_next_ch (
    .mask     (nc_mask_s),
    .cur_idx  (ch_r),
    .first    (nc_first_s),
    .next_idx (nc_idx_s),
    .found    (nc_found_s)
  );

  // Next-state and next-register values for the whole sequencer.
  always_comb begin
    state_nxt_s  = state_r;
    ch_nxt_s     = ch_r;
    mask_nxt_s   = mask_r;
    settle_nxt_s = settle_r;
    snap_nxt_s   = snap_r;
    data_nxt_s   = data_r;
    chg_nxt_s    = chg_r;
    prev_nxt_s   = prev_r;
    valid_nxt_s  = valid_r;
    err_nxt_s    = err_r;
    case (state_r)
      IDLE: begin
        if (start || cont) begin
          mask_nxt_s = ch_mask;
          snap_nxt_s = '0;
          err_nxt_s  = start ? 1'b0 : err_r;
          if (nc_found_s) begin
            state_nxt_s  = SELECT;
            ch_nxt_s     = nc_idx_s;
            settle_nxt_s = SETTLE_INIT;
          end else begin
            state_nxt_s = DONE;
            data_nxt_s  = '0;
            chg_nxt_s   = data_nxt_s ^ prev_r;
            valid_nxt_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SELECT: begin
        if (settle_r == SETTLE_W'(0)) begin
          state_nxt_s = SAMPLE;
        end else begin
          settle_nxt_s = settle_r - SETTLE_W'(1);
        end
      end
      SAMPLE: begin
        snap_nxt_s[ch_r] = mux_y;
        err_nxt_s        = err_r | yw_fault(mux_y, mux_w);
        if (nc_found_s) begin
          state_nxt_s  = SELECT;
          ch_nxt_s     = nc_idx_s;
          settle_nxt_s = SETTLE_INIT;
        end else begin
          state_nxt_s = DONE;
          data_nxt_s  = snap_nxt_s;
          chg_nxt_s   = snap_nxt_s ^ prev_r;
          valid_nxt_s = 1'b1;
        end
      end
      DONE: begin
        if (valid_r && scan_ready) begin
          prev_nxt_s  = data_r;
          valid_nxt_s = 1'b0;
          if (cont && nc_found_s) begin
            state_nxt_s  = SELECT;
            mask_nxt_s   = ch_mask;
            snap_nxt_s   = '0;
            ch_nxt_s     = nc_idx_s;
            settle_nxt_s = SETTLE_INIT;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        valid_nxt_s = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == SELECT) || (state_nxt_s == SAMPLE);
  end

  // State register and every externally visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      ch_r     <= '0;
      mask_r   <= '0;
      settle_r <= '0;
      snap_r   <= '0;
      data_r   <= '0;
      chg_r    <= '0;
      prev_r   <= '0;
      valid_r  <= 1'b0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      mux_g_r  <= 1'b1;
    end else begin
      state_r  <= state_nxt_s;
      ch_r     <= ch_nxt_s;
      mask_r   <= mask_nxt_s;
      settle_r <= settle_nxt_s;
      snap_r   <= snap_nxt_s;
      data_r   <= data_nxt_s;
      chg_r    <= chg_nxt_s;
      prev_r   <= prev_nxt_s;
      valid_r  <= valid_nxt_s;
      err_r    <= err_nxt_s;
      busy_r   <= busy_nxt_s;
      mux_g_r  <= ~busy_nxt_s;
    end
  end

  assign mux_g      = mux_g_r;
  assign mux_a      = ch_r[0];
  assign mux_b      = ch_r[1];
  assign mux_c      = ch_r[2];
  assign scan_data  = data_r;
  assign scan_valid = valid_r;
  assign chg        = chg_r;
  assign busy       = busy_r;
  assign err        = err_r;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Scoreboard bench for mux_scan_ctrl: a selector model feeds the DUT, stimulus
// pushes expected snapshots, and a monitor checks each one as it is presented.
module tb_mux_scan_ctrl;

  localparam int SETTLE = 2;
  localparam int STEP   = SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       cont = 1'b0;
  logic       scan_ready = 1'b0;
  logic [7:0] ch_mask = 8'h00;
  logic       mux_g, mux_a, mux_b, mux_c, mux_y, mux_w;
  logic [7:0] scan_data, chg;
  logic       scan_valid, busy, err;

  logic [7:0] pat_r = 8'h00;
  int         fault_ch = -1;
  int         cyc = 0;
  int         n_tests = 0;
  int         n_fail = 0;

  typedef struct {
    logic [7:0] mask;
    logic [7:0] data;
    logic [7:0] chg;
    logic       err;
    bit         auto_ref;
    int         ref_cyc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] prev_m = 8'h00;
  logic       err_m = 1'b0;

  mux_scan_ctrl #(.SETTLE_CYCLES(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cont(cont), .ch_mask(ch_mask),
    .mux_g(mux_g), .mux_a(mux_a), .mux_b(mux_b), .mux_c(mux_c),
    .mux_y(mux_y), .mux_w(mux_w),
    .scan_data(scan_data), .scan_valid(scan_valid), .scan_ready(scan_ready),
    .chg(chg), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8:1 selector; a fault channel makes w track y instead of ~y.
  logic [2:0] sel_s;
  assign sel_s = {mux_c, mux_b, mux_a};
  assign mux_y = mux_g ? 1'b0 : pat_r[sel_s];
  assign mux_w = (!mux_g && (int'(sel_s) == fault_ch)) ? mux_y : ~mux_y;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] sel_code_of(input logic [7:0] m);
    logic [31:0] c;
    c = 32'h0;
    for (int i = 0; i < 8; i++)
      if (m[i]) c = {c[27:0], 1'b1, 3'(i)};
    return c;
  endfunction

  task automatic push_exp(input logic [7:0] m, input logic [7:0] pat, input int fch,
                          input bit is_start, input bit auto_ref);
    exp_t e;
    e.mask = m;
    e.data = pat & m;
    e.chg  = e.data ^ prev_m;
    prev_m = e.data;
    if (is_start) err_m = 1'b0;
    if (fch >= 0 && m[fch]) err_m = 1'b1;
    e.err      = err_m;
    e.auto_ref = auto_ref;
    e.ref_cyc  = cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: samples just after each rising edge and checks every presented snapshot.
  logic        prev_valid = 1'b0;
  logic        prev_g = 1'b1;
  logic [2:0]  prev_sel = 3'd0;
  logic [31:0] sel_code = 32'h0;
  logic [7:0]  held_d = 8'h00, held_c = 8'h00;
  int          last_hs = 0;
  int          ref_c;
  exp_t        mon_e;

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      prev_valid = 1'b0;
      sel_code   = 32'h0;
    end else begin
      if (prev_valid && scan_ready) begin
        last_hs = cyc;
        check("valid_falls_after_handshake", {31'h0, scan_valid}, 32'h0);
      end
      if (!mux_g && (prev_g || sel_s != prev_sel))
        sel_code = {sel_code[27:0], 1'b1, sel_s};
      if (scan_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_valid: scan_valid=1 with no scan outstanding (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          ref_c = mon_e.auto_ref ? last_hs - 1 : mon_e.ref_cyc;
          check("latency", cyc - ref_c, $countones(mon_e.mask) * STEP + 1);
          check("scan_data", {24'h0, scan_data}, {24'h0, mon_e.data});
          check("chg", {24'h0, chg}, {24'h0, mon_e.chg});
          check("err", {31'h0, err}, {31'h0, mon_e.err});
          check("select_sequence", sel_code, sel_code_of(mon_e.mask));
        end
        held_d   = scan_data;
        held_c   = chg;
        sel_code = 32'h0;
      end else if (scan_valid && prev_valid) begin
        check("hold_data", {24'h0, scan_data}, {24'h0, held_d});
        check("hold_chg", {24'h0, chg}, {24'h0, held_c});
      end
    end
    prev_valid = scan_valid;
    prev_g     = mux_g;
    prev_sel   = sel_s;
  end

  // Waits for scan_valid, toggling scan_ready meanwhile (it must be ignored while idle).
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (scan_valid) begin
        ok = 1'b1;
        break;
      end
      scan_ready = 1'($urandom_range(0, 1));
    end
    scan_ready = 1'b0;
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: scan_valid=0, expected 1 within 200 cycles (cycle %0d)", cyc);
    end
  endtask

  task automatic pulse_ready(input int hold);
    repeat (hold) @(negedge clk);
    scan_ready = 1'b1;
    @(negedge clk);
    scan_ready = 1'b0;
  endtask

  task automatic single_scan(input logic [7:0] m, input logic [7:0] pat, input int fch,
                             input int hold, input bit scramble);
    bit ok;
    @(negedge clk);
    ch_mask  = m;
    pat_r    = pat;
    fault_ch = fch;
    start    = 1'b1;
    push_exp(m, pat, fch, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check("err_cleared_by_start", {31'h0, err}, 32'h0);
    check("busy_after_start", {31'h0, busy}, {31'h0, (m != 8'h00)});
    if (scramble) ch_mask = 8'($urandom);
    wait_valid(ok);
    if (ok) pulse_ready(hold);
  endtask

  task automatic cont_pair(input logic [7:0] m, input logic [7:0] pat1, input logic [7:0] pat2,
                           input int fch1, input int hold1, input int hold2);
    bit ok;
    @(negedge clk);
    ch_mask  = m;
    pat_r    = pat1;
    fault_ch = fch1;
    cont     = 1'b1;
    start    = 1'b1;
    push_exp(m, pat1, fch1, 1'b1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    if (ok) begin
      repeat (hold1) @(negedge clk);
      pat_r    = pat2;
      fault_ch = -1;
      push_exp(m, pat2, -1, 1'b0, 1'b1);
      scan_ready = 1'b1;
      @(negedge clk);
      scan_ready = 1'b0;
      cont       = 1'b0;
      wait_valid(ok);
      if (ok) pulse_ready(hold2);
    end else begin
      cont = 1'b0;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mux_g"}, {31'h0, mux_g}, 32'h1);
    check({tag, "_select"}, {29'h0, sel_s}, 32'h0);
    check({tag, "_scan_data"}, {24'h0, scan_data}, 32'h0);
    check({tag, "_chg"}, {24'h0, chg}, 32'h0);
    check({tag, "_scan_valid"}, {31'h0, scan_valid}, 32'h0);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_err"}, {31'h0, err}, 32'h0);
  endtask

  initial begin
    bit         ok;
    logic [7:0] m;
    int         fch;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    single_scan(8'hFF, 8'hA5, -1, 0, 1'b0);
    single_scan(8'h11, 8'hFF, -1, 2, 1'b1);
    single_scan(8'h00, 8'h3C, -1, 1, 1'b0);
    cont_pair(8'hFF, 8'hA5, 8'h5A, -1, 10, 0);

    cont_pair(8'hFF, 8'($urandom), 8'($urandom), 3, 2, 1);
    @(negedge clk);
    check("err_sticky_in_idle", {31'h0, err}, {31'h0, err_m});
    single_scan(8'hF0, 8'($urandom), -1, 0, 1'b0);

    // Abort a scan during channel 2 select; err is armed via a fault on channel 1.
    @(negedge clk);
    ch_mask  = 8'hFF;
    pat_r    = 8'($urandom);
    fault_ch = 1;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok    = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (!mux_g && sel_s == 3'd2) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_channel2_select", {31'h0, ok}, 32'h1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midscan_reset");
    prev_m   = 8'h00;
    err_m    = 1'b0;
    fault_ch = -1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("no_valid_after_abort", {31'h0, scan_valid}, 32'h0);
    single_scan(8'hFF, 8'($urandom), -1, 0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      m   = 8'($urandom);
      fch = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      if ($urandom_range(0, 4) == 0) begin
        if (m == 8'h00) m = 8'h80;
        cont_pair(m, 8'($urandom), 8'($urandom), fch, $urandom_range(0, 4), $urandom_range(0, 4));
      end else begin
        single_scan(m, 8'($urandom), fch, $urandom_range(0, 4), 1'b1);
      end
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
Name: mux_scan_ctrl

Overview:
- Sequencer for the team's 8:1 data-selector block (active-low strobe g; selects a/b/c; outputs y and complement w).
- Steps the select lines through all enabled channels, waits a settle time, samples y, and assembles an 8-bit snapshot.
- Delivers each snapshot over a valid/ready handshake, with per-bit change flags and a y/w integrity error.
- Sits between the selector and any consumer that needs a parallel view of 8 serialised inputs.

Parameters:
- SETTLE_CYCLES, 2, cycles the select lines and strobe are held before sampling; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a scan from IDLE.
- cont  in  1  continuous mode; a new scan starts automatically after each handshake.
- ch_mask  in  8  channel enables; bit i enables channel i.
- mux_g  out  1  strobe to the selector, active low.
- mux_a  out  1  select LSB.
- mux_b  out  1  select middle bit.
- mux_c  out  1  select MSB.
- mux_y  in  1  selector data output.
- mux_w  in  1  selector complement output.
- scan_data  out  8  snapshot; bit i is the sample of channel i.
- scan_valid  out  1  snapshot available.
- scan_ready  in  1  consumer accepts the snapshot.
- chg  out  8  bits that differ from the previous delivered snapshot.
- busy  out  1  scan in progress (states other than IDLE and DONE).
- err  out  1  sticky integrity error.

Behaviour:
- Reset (async, rst_n=0): all outputs driven from registers and cleared immediately.
  - mux_g=1, mux_a=mux_b=mux_c=0, scan_data=0, chg=0.
  - scan_valid=0, busy=0, err=0, state=IDLE, previous-snapshot register=0.
- Channel index is {c,b,a}, so channel 5 drives c=1, b=0, a=1.
- ch_mask is captured at scan start; changes during a scan have no effect until the next scan.
- FSM states: IDLE, SELECT, SAMPLE, DONE.
- IDLE:
  - mux_g=1.
  - start=1 or cont=1 with no snapshot pending: go to SELECT with the lowest enabled channel.
  - If the captured mask is 0: go directly to DONE with scan_data=0.
- SELECT:
  - Drive the channel select, mux_g=0, and hold for SETTLE_CYCLES cycles using a settle counter.
  - Then go to SAMPLE.
- SAMPLE (one cycle):
  - Write the sample bit from mux_y.
  - If mux_y==mux_w, set err.
  - Next enabled channel above the current one exists: go to SELECT with that channel. Otherwise go to DONE.
  - Disabled channels are skipped (zero cycles spent) and their snapshot bit is 0.
- Per-channel cost is SETTLE_CYCLES+1 cycles.
- Full-scan latency from the start pulse to scan_valid is N*(SETTLE_CYCLES+1)+1 cycles, where N is the number of enabled channels.
- DONE entry:
  - scan_data, chg (= new XOR previous) and scan_valid=1 update together.
  - mux_g returns to 1.
- DONE hold:
  - scan_data and chg stay stable while scan_valid=1 and scan_ready=0.
- DONE handshake (scan_valid & scan_ready):
  - Previous-snapshot register <= scan_data, and scan_valid falls the next cycle.
  - cont=1: go straight to SELECT, with the first channel driven the cycle after the handshake.
  - Otherwise go to IDLE.
- scan_ready while scan_valid=0 is ignored.
- start while busy or in DONE is ignored.
- cont falling mid-scan: the current scan completes and is delivered, then the FSM goes to IDLE.
- err is sticky: cleared only by reset or by an accepted start pulse in IDLE.
- Reset mid-scan aborts immediately; no partial snapshot is delivered.

Decomposition:
- Package mux_scan_pkg:
  - state enum {IDLE, SELECT, SAMPLE, DONE}.
  - CH_COUNT=8 and CH_IDX_W=3.
  - SETTLE counter width constant (4).
- Sub-module mux_scan_next_ch (combinational):
  - Inputs: mask, current index, and a first flag.
  - Outputs: next enabled index and a found flag.
  - Implemented as a priority encoder over the mask bits above the current index.

Test Plan:
- Single scan, SETTLE_CYCLES=2, ch_mask=8'hFF, mux_y driven from pattern 8'hA5 by select, w=~y.
  - scan_valid exactly 25 cycles after start; scan_data=8'hA5, chg=8'hA5, err=0.
  - Select sequence 0..7.
- Sparse mask ch_mask=8'h11, pattern 8'hFF.
  - Only channels 0 and 4 selected; scan_data=8'h11; valid after 7 cycles.
- All-masked scan, ch_mask=8'h00.
  - valid 1 cycle after start; scan_data=0; mux_g stays 1.
- Backpressure and continuous mode: cont=1, hold scan_ready=0 for 10 cycles, then pulse it; pattern changes to 8'h5A.
  - Data is held stable while ready=0.
  - The second scan starts the cycle after the handshake; second scan_data=8'h5A, chg=8'hFF.
- Integrity fault: force mux_w=mux_y on channel 3.
  - err=1, remains 1 through the next scan, and clears on the next start from IDLE.
- Reset mid-scan: assert rst_n=0 during the SELECT of channel 2.
  - All outputs take reset values in the same cycle, no scan_valid follows, and a fresh start works normally.
